// File: rtl/packet_pkg.sv
// Shared definitions for the packet framer / deframer pair.
package packet_pkg;

    // Header field layout
    localparam int SEQ_MSB = 31;
    localparam int SEQ_LSB = 16;
    localparam int LEN_MSB = 15;
    localparam int LEN_LSB = 0;

    localparam logic [31:0] FOOTER_WORD_DEF = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        FOOTER  = 2'd2,
        DROP    = 2'd3
    } state_t;

    // Per-packet error flags, packed MSB-first as seq, len, footer, oversize
    typedef struct packed {
        logic seq;
        logic len;
        logic footer;
        logic oversize;
    } err_t;

endpackage

// File: rtl/packet_seq_checker.sv
// Tracks the expected sequence number and flags header mismatches.
module packet_seq_checker
    import packet_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       hdr_accept,
    input  logic [SEQ_MSB-SEQ_LSB:0]   seq_in,
    output logic                       seq_err
);

    logic [SEQ_MSB-SEQ_LSB:0] exp_seq;

    assign seq_err = (seq_in != exp_seq);

    // Always follow the received value so one gap reports only once
    always_ff @(posedge clock) begin
        if (reset)
            exp_seq <= '0;
        else if (hdr_accept)
            exp_seq <= seq_in + 1'b1;
    end

endmodule

// File: rtl/packet_deframer.sv
// Receive-side deframer: strips header/footer, forwards payload one cycle
// later and reports per-packet integrity status and counters.
module packet_deframer
    import packet_pkg::*;
#(
    parameter int          MAX_WORDS   = 381,
    parameter logic [31:0] FOOTER_WORD = FOOTER_WORD_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] dataIn,
    input  logic        validIn,
    input  logic        lastIn,
    output logic [31:0] payloadData,
    output logic        payloadValid,
    output logic        payloadLast,
    output logic        pktDone,
    output logic        pktOk,
    output logic        errSeq,
    output logic        errLen,
    output logic        errFooter,
    output logic        errOversize,
    output logic [15:0] rxSeq,
    output logic [15:0] rxLen,
    output logic [15:0] goodCount,
    output logic [15:0] badCount
);

    localparam logic [16:0] MAX_W17 = 17'(MAX_WORDS);

    state_t      state;
    logic [15:0] idx;
    err_t        flags;      // accumulating flags of the packet in flight
    err_t        nflags;     // flags including this cycle's word
    logic        fin;
    logic        fwd;
    logic        fwd_last;
    logic        seq_err;
    logic        hdr_accept;
    logic [15:0] hdr_len;
    logic        hdr_over;

    assign hdr_len    = dataIn[LEN_MSB:LEN_LSB];
    // 17-bit compare so LEN=16'hFFFF does not wrap to zero
    assign hdr_over   = ({1'b0, hdr_len} + 17'd1) > MAX_W17;
    assign hdr_accept = validIn && (state == IDLE);

    packet_seq_checker u_seq (
        .clock      (clock),
        .reset      (reset),
        .hdr_accept (hdr_accept),
        .seq_in     (dataIn[SEQ_MSB:SEQ_LSB]),
        .seq_err    (seq_err)
    );

    // Decode the accepted word: error events, forwarding and packet end
    always_comb begin
        nflags   = flags;
        fin      = 1'b0;
        fwd      = 1'b0;
        fwd_last = 1'b0;
        if (validIn) begin
            case (state)
                IDLE: begin
                    nflags = '{seq: seq_err, len: 1'b0, footer: 1'b0, oversize: hdr_over};
                    if (!hdr_over && lastIn) begin
                        nflags.len = 1'b1;
                        fin        = 1'b1;
                    end
                end
                PAYLOAD: begin
                    fwd      = 1'b1;
                    fwd_last = (idx == rxLen) || lastIn;
                    if (lastIn) begin
                        nflags.len = 1'b1;
                        fin        = 1'b1;
                    end
                end
                FOOTER: begin
                    if (lastIn) begin
                        fin = 1'b1;
                        if (dataIn != FOOTER_WORD)
                            nflags.footer = 1'b1;
                    end else begin
                        nflags.footer = 1'b1;
                    end
                end
                DROP: fin = lastIn;
                default: ;
            endcase
        end
    end

    // Packet FSM with registered payload, status and counter outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            flags        <= '0;
            payloadData  <= '0;
            payloadValid <= 1'b0;
            payloadLast  <= 1'b0;
            pktDone      <= 1'b0;
            pktOk        <= 1'b0;
            errSeq       <= 1'b0;
            errLen       <= 1'b0;
            errFooter    <= 1'b0;
            errOversize  <= 1'b0;
            rxSeq        <= '0;
            rxLen        <= '0;
            goodCount    <= '0;
            badCount     <= '0;
        end else begin
            payloadValid <= fwd;
            payloadLast  <= fwd_last;
            pktDone      <= fin;
            if (fwd)
                payloadData <= dataIn;
            if (validIn) begin
                flags <= nflags;
                case (state)
                    IDLE: begin
                        rxSeq <= dataIn[SEQ_MSB:SEQ_LSB];
                        rxLen <= hdr_len;
                        idx   <= '0;
                        if (hdr_over)
                            state <= DROP;
                        else if (!lastIn)
                            state <= PAYLOAD;
                    end
                    PAYLOAD: begin
                        if (lastIn)
                            state <= IDLE;
                        else if (idx == rxLen)
                            state <= FOOTER;
                        else
                            idx <= idx + 16'd1;
                    end
                    FOOTER: state <= lastIn ? IDLE : DROP;
                    DROP:   if (lastIn) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
            // Status becomes visible only when its packet finishes
            if (fin) begin
                pktOk       <= (nflags == '0);
                errSeq      <= nflags.seq;
                errLen      <= nflags.len;
                errFooter   <= nflags.footer;
                errOversize <= nflags.oversize;
                if (nflags == '0) begin
                    if (goodCount != 16'hFFFF)
                        goodCount <= goodCount + 16'd1;
                end else begin
                    if (badCount != 16'hFFFF)
                        badCount <= badCount + 16'd1;
                end
            end
        end
    end

endmodule
